// File: rtl/shift_deserializer_if.sv
// shift_deserializer_if: serial-side strobes and word-side valid/ready bundle for the deserializer
interface shift_deserializer_if #(parameter int WIDTH = 8);
   logic enable;
   logic sync;
   logic data_in;
   logic ready;
   logic clr_ovf;
   logic [WIDTH-1:0] data_out;
   logic valid;
   logic busy;
   logic overflow;
   modport master (output enable, sync, data_in, ready, clr_ovf, input data_out, valid, busy, overflow);
   modport slave (input enable, sync, data_in, ready, clr_ovf, output data_out, valid, busy, overflow);
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out receiver with one-word holding register and sticky overflow
module shift_deserializer #(
   parameter int WIDTH = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic clk,
   input logic rst,
   shift_deserializer_if.slave s
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   logic [WIDTH-1:0] sr, sr_nxt, data_out;
   logic [CW-1:0] cnt, ecnt;
   logic valid, overflow, wc, pop;
   always_comb begin
      ecnt = s.sync ? '0 : cnt;
      sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], s.data_in} : {s.data_in, sr[WIDTH-1:1]};
      wc = s.enable && (ecnt == CW'(WIDTH - 1));
      pop = valid && s.ready;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
         cnt <= '0;
         data_out <= '0;
         valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (s.enable) begin
            sr <= sr_nxt;
            cnt <= wc ? '0 : ecnt + CW'(1);
         end else if (s.sync) cnt <= '0;
         if (wc && (!valid || pop)) begin
            data_out <= sr_nxt;
            valid <= 1'b1;
         end else if (!wc && pop) valid <= 1'b0;
         // a drop on the same edge as clr_ovf must leave the flag set
         if (wc && valid && !s.ready) overflow <= 1'b1;
         else if (s.clr_ovf) overflow <= 1'b0;
      end
   end
   assign s.data_out = data_out;
   assign s.valid = valid;
   assign s.busy = (cnt != '0);
   assign s.overflow = overflow;
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed scenarios on MSB-first and LSB-first instances fed the same bit stream
module tb_shift_deserializer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   shift_deserializer_if #(.WIDTH(8)) m ();
   shift_deserializer_if #(.WIDTH(8)) l ();
   shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .s(m.slave));
   shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .s(l.slave));
   assign l.enable = m.enable;
   assign l.sync = m.sync;
   assign l.data_in = m.data_in;
   assign l.ready = m.ready;
   assign l.clr_ovf = m.clr_ovf;
   initial forever #5 clk = ~clk;

   task automatic cycle(input logic en, input logic d, input logic syn);
      m.enable = en;
      m.data_in = d;
      m.sync = syn;
      @(negedge clk);
      m.enable = 1'b0;
      m.sync = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) cycle(1'b1, w[i], 1'b0);
   endtask

   task automatic test_reset();
      m.enable = 0; m.sync = 0; m.data_in = 0; m.ready = 1; m.clr_ovf = 0;
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({m.data_out, m.valid, m.busy, m.overflow} !== 11'd0) begin
         errors++;
         $display("FAIL reset: got %h v%b b%b o%b want 00 v0 b0 o0", m.data_out, m.valid, m.busy, m.overflow);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b1, w[i], 1'b0);
         if (i == 7) begin
            checks++;
            if (m.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", m.busy); end
         end
      end
      checks++;
      if (m.valid !== 1'b1 || m.data_out !== 8'hA5 || m.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_word: got %h v%b b%b want a5 v1 b0", m.data_out, m.valid, m.busy);
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (m.valid !== 1'b0 || m.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop: got v%b b%b want v0 b0", m.valid, m.busy);
      end
   endtask

   task automatic test_bit_order();
      send_word(8'h80);
      checks++;
      if (m.data_out !== 8'h80 || m.valid !== 1'b1) begin
         errors++;
         $display("FAIL order_msb: got %h v%b want 80 v1", m.data_out, m.valid);
      end
      checks++;
      if (l.data_out !== 8'h01 || l.valid !== 1'b1) begin
         errors++;
         $display("FAIL order_lsb: got %h v%b want 01 v1", l.data_out, l.valid);
      end
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_gaps();
      logic [7:0] w = 8'h3C;
      int vcount = 0;
      bit gap_bad = 0;
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b1, w[i], 1'b0);
         if (m.valid) vcount++;
         if (i != 0) for (int g = 0; g < 2; g++) begin
            cycle(1'b0, 1'b1, 1'b0);
            if (m.valid || !m.busy) gap_bad = 1;
         end
      end
      checks++;
      if (m.data_out !== 8'h3C || vcount != 1 || gap_bad) begin
         errors++;
         $display("FAIL gaps: got %h valids %0d gap_bad %0d want 3c valids 1 gap_bad 0", m.data_out, vcount, gap_bad);
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (m.valid !== 1'b0) begin errors++; $display("FAIL gaps_pop: got v%b want v0", m.valid); end
   endtask

   task automatic test_backpressure();
      m.ready = 1'b0;
      send_word(8'h12);
      checks++;
      if (m.valid !== 1'b1 || m.data_out !== 8'h12 || m.overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp_first: got %h v%b o%b want 12 v1 o0", m.data_out, m.valid, m.overflow);
      end
      send_word(8'h34);
      checks++;
      if (m.valid !== 1'b1 || m.data_out !== 8'h12 || m.overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_drop: got %h v%b o%b want 12 v1 o1", m.data_out, m.valid, m.overflow);
      end
      m.clr_ovf = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      m.clr_ovf = 1'b0;
      checks++;
      if (m.overflow !== 1'b0) begin errors++; $display("FAIL bp_clr: got o%b want o0", m.overflow); end
      for (int i = 7; i >= 0; i--) begin
         m.clr_ovf = (i == 0);
         cycle(1'b1, i[0] ^ i[1], 1'b0);
      end
      m.clr_ovf = 1'b0;
      checks++;
      if (m.overflow !== 1'b1 || m.data_out !== 8'h12) begin
         errors++;
         $display("FAIL bp_set_wins: got %h o%b want 12 o1", m.data_out, m.overflow);
      end
      m.ready = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (m.valid !== 1'b0 || m.data_out !== 8'h12) begin
         errors++;
         $display("FAIL bp_pop: got %h v%b want 12 v0", m.data_out, m.valid);
      end
      m.clr_ovf = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      m.clr_ovf = 1'b0;
      checks++;
      if (m.overflow !== 1'b0) begin errors++; $display("FAIL bp_clr2: got o%b want o0", m.overflow); end
   endtask

   task automatic test_sync();
      logic [7:0] w = 8'h5A;
      int vcount = 0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b1, w[i], i == 7);
         if (m.valid) vcount++;
      end
      checks++;
      if (m.data_out !== 8'h5A || vcount != 1 || l.data_out !== 8'h5A) begin
         errors++;
         $display("FAIL sync: got %h/%h valids %0d want 5a/5a valids 1", m.data_out, l.data_out, vcount);
      end
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      checks++;
      if (m.valid !== 1'b0 || m.busy !== 1'b1) begin
         errors++;
         $display("FAIL sync_last: got v%b b%b want v0 b1", m.valid, m.busy);
      end
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (m.valid !== 1'b1 || m.data_out !== 8'h80) begin
         errors++;
         $display("FAIL sync_last_word: got %h v%b want 80 v1", m.data_out, m.valid);
      end
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      send_word(8'hFF);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({m.data_out, m.valid, m.busy, m.overflow} !== 11'd0) begin
         errors++;
         $display("FAIL async_rst: got %h v%b b%b o%b want 00 v0 b0 o0", m.data_out, m.valid, m.busy, m.overflow);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      send_word(8'hF0);
      checks++;
      if (m.data_out !== 8'hF0 || m.valid !== 1'b1 || l.data_out !== 8'h0F) begin
         errors++;
         $display("FAIL after_rst: got %h/%h v%b want f0/0f v1", m.data_out, l.data_out, m.valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bit_order();
      test_gaps();
      test_backpressure();
      test_sync();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
